// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 divider: FSM encodings, status levels
// and the result width used by the 32-bit integer pipeline.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Levels presented on busy / done
  localparam logic DIV_FREE         = 1'b0;
  localparam logic DIV_BUSY         = 1'b1;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NONE  = 1'b0;

  // {remainder, quotient} width for the 32-bit integer datapath
  localparam int DOUBLE_REG_WIDTH = 64;

endpackage

// File: rtl/div_lzc.sv
// Combinational leading-zero counter. An all-zero input returns WIDTH.
module div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         value,
  output logic [$clog2(WIDTH):0]   count
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Scan from the MSB; the first set bit fixes the count
  always_comb begin
    logic found;
    count = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider with LoongArch div/mod semantics,
// optional leading-zero early-out, cancel and a registered divide-by-zero flag.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cancel,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Two's-complement negate when neg is set; MIN maps onto itself (wrap)
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_state_e       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr_mag;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic signed [WIDTH-1:0] dividend_s;
  logic signed [WIDTH-1:0] divisor_s;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [CNT_W-1:0] lz;
  logic [CNT_W-1:0] n_iter;
  logic             can_accept;

  logic [WIDTH+1:0] diff;
  logic             trial_neg;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign dividend_s = dividend;
  assign divisor_s  = divisor;
  assign dvd_neg    = signed_op & (dividend_s < 0);
  assign dvs_neg    = signed_op & (divisor_s < 0);
  assign dvd_mag    = cond_neg(dividend, dvd_neg);
  assign dvs_mag    = cond_neg(divisor, dvs_neg);
  assign can_accept = (state == DIV_IDLE) || (state == DIV_DONE);

  generate
    if (EARLY_OUT) begin : g_lzc
      div_lzc #(.WIDTH(WIDTH)) u_lzc (
        .value (dvd_mag),
        .count (lz)
      );
    end else begin : g_no_lzc
      assign lz = '0;
    end
  endgenerate

  // A zero dividend under early-out gives lz == WIDTH and hence no iterations
  assign n_iter = CNT_W'(WIDTH) - lz;

  // One restoring step: trial-subtract |divisor| from {partial, next bit}
  assign diff      = {rem, quo[WIDTH-1]} - {2'b00, dvsr_mag};
  assign trial_neg = diff[WIDTH+1];
  assign rem_nxt   = trial_neg ? {rem[WIDTH-1:0], quo[WIDTH-1]} : diff[WIDTH:0];
  assign quo_nxt   = {quo[WIDTH-2:0], ~trial_neg};

  assign busy = (state == DIV_CALC) ? DIV_BUSY : DIV_FREE;
  assign done = (state == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NONE;

  // Control FSM with the iterating datapath and registered result/flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DIV_IDLE;
      rem         <= '0;
      quo         <= '0;
      dvsr_mag    <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (cancel) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE, DIV_DONE: begin
          if (start && can_accept) begin
            if (divisor == '0) begin
              result      <= {dividend, {WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
              state       <= DIV_DONE;
            end else if (n_iter == '0) begin
              result      <= '0;
              div_by_zero <= 1'b0;
              state       <= DIV_DONE;
            end else begin
              rem      <= '0;
              quo      <= dvd_mag << lz;
              dvsr_mag <= dvs_mag;
              cnt      <= n_iter;
              neg_q    <= dvd_neg ^ dvs_neg;
              neg_r    <= dvd_neg;
              state    <= DIV_CALC;
            end
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result      <= {cond_neg(rem_nxt[WIDTH-1:0], neg_r),
                            cond_neg(quo_nxt, neg_q)};
            div_by_zero <= 1'b0;
            state       <= DIV_DONE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
